// File: rtl/noc_cmd_pkg.sv
// Shared NoC command definitions.
// Source tags and the command-width rule used by the 1x2/2x1 nodes.
package noc_cmd_pkg;

  localparam logic SRC_TAG_HIGH = 1'b1;
  localparam logic SRC_TAG_LOW  = 1'b0;

  function automatic int out_cmd_width(
    input int in_w,
    input int tag_w
  );
    return in_w + tag_w;
  endfunction

endpackage

// File: rtl/collect_2x1_cmd_flow_seq_if.sv
// Two-input merge bundle toward one output stream.
// slave: merge node side; master: producer/consumer side.
interface collect_2x1_cmd_flow_seq_if
  import noc_cmd_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int IN_COMMAND_WIDTH  = 1,
  parameter int OUT_COMMAND_WIDTH = out_cmd_width(IN_COMMAND_WIDTH, 1)
);

  logic                          i_en;
  logic [1:0]                    i_valid;
  logic [2*DATA_WIDTH-1:0]       i_data_bus;
  logic [2*IN_COMMAND_WIDTH-1:0] i_cmd;
  logic [1:0]                    o_ready;
  logic                          o_valid;
  logic [DATA_WIDTH-1:0]         o_data_bus;
  logic [OUT_COMMAND_WIDTH-1:0]  o_cmd;
  logic                          i_ready;

  modport slave (
    input  i_en, i_valid, i_data_bus, i_cmd, i_ready,
    output o_ready, o_valid, o_data_bus, o_cmd
  );

  modport master (
    output i_en, i_valid, i_data_bus, i_cmd, i_ready,
    input  o_ready, o_valid, o_data_bus, o_cmd
  );

endinterface

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, pointers wrap naturally.
// rdata is the raw head slot; the caller qualifies it with empty.
module noc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        (do_push & ~do_pop): count <= count + CW'(1);
        (do_pop & ~do_push): count <= count - CW'(1);
        default:             count <= count;
      endcase
    end
  end

endmodule

// File: rtl/collect_2x1_cmd_flow_seq.sv
// 2x1 collect node: round-robin merge of high/low inputs into a FIFO.
// The winner's source tag is prepended to its command on the way in.
module collect_2x1_cmd_flow_seq
  import noc_cmd_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int DESTINATION_TAG_WIDTH = 1,
  parameter int IN_COMMAND_WIDTH      = 1,
  parameter int OUT_COMMAND_WIDTH     =
    out_cmd_width(IN_COMMAND_WIDTH, DESTINATION_TAG_WIDTH),
  parameter int FIFO_DEPTH            = 2
) (
  input logic clk,
  input logic rst,
  collect_2x1_cmd_flow_seq_if.slave bus
);

  localparam int W  = DATA_WIDTH + OUT_COMMAND_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = DATA_WIDTH;
  localparam int IW = IN_COMMAND_WIDTH;

  if (DESTINATION_TAG_WIDTH != 1) begin : g_bad_tag
    $error("collect_2x1: DESTINATION_TAG_WIDTH must be 1");
  end
  if (IN_COMMAND_WIDTH < 1) begin : g_bad_cmd
    $error("collect_2x1: IN_COMMAND_WIDTH must be >= 1");
  end
  if (OUT_COMMAND_WIDTH != IN_COMMAND_WIDTH + DESTINATION_TAG_WIDTH)
  begin : g_bad_out
    $error("collect_2x1: OUT_COMMAND_WIDTH is derived");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_depth
    $error("collect_2x1: FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic          rr_ptr;
  logic [1:0]    grant;
  logic          push;
  logic          pop;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  always_comb begin
    grant = bus.i_valid;
    if (&bus.i_valid) begin
      grant = rr_ptr ? 2'b10 : 2'b01;
    end
  end

  // Ready depends only on registered FIFO state, never on i_ready.
  assign bus.o_ready = {2{bus.i_en & ~rst & ~full}} & grant;
  assign push = |(bus.i_valid & bus.o_ready);

  always_comb begin
    if (bus.o_ready[1]) begin
      wdata = {bus.i_data_bus[2*DW-1:DW], SRC_TAG_HIGH,
               bus.i_cmd[2*IW-1:IW]};
    end else begin
      wdata = {bus.i_data_bus[DW-1:0], SRC_TAG_LOW,
               bus.i_cmd[IW-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b1;
    end else if (push) begin
      rr_ptr <= ~bus.o_ready[1];
    end
  end

  assign bus.o_valid = ~rst & (count != '0);
  assign pop = bus.o_valid & bus.i_ready;
  assign {bus.o_data_bus, bus.o_cmd} = (rst | empty) ? '0 : rdata;

  noc_sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_collect_2x1_cmd_flow_seq.sv
// Bench for the 2x1 collect node: queue model plus directed pins.
// Inputs change at negedge; outputs are compared 1 time unit later.
module tb_collect_2x1_cmd_flow_seq;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  collect_2x1_cmd_flow_seq_if #(
    .DATA_WIDTH        (DW),
    .IN_COMMAND_WIDTH  (1),
    .OUT_COMMAND_WIDTH (2)
  ) bus ();

  collect_2x1_cmd_flow_seq #(
    .DATA_WIDTH            (DW),
    .DESTINATION_TAG_WIDTH (1),
    .IN_COMMAND_WIDTH      (1),
    .FIFO_DEPTH            (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: queue of {data, tag, cmd} entries and the preferred input.
  logic [33:0] q[$];
  logic        rr = 1'b1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step(
    input logic        r,
    input logic        en,
    input logic [1:0]  v,
    input logic [31:0] dh,
    input logic [31:0] dl,
    input logic        ch,
    input logic        cl,
    input logic        rdy
  );
    logic [1:0]  gr;
    logic [1:0]  er;
    logic [33:0] head;
    logic        pop;
    @(negedge clk);
    rst            = r;
    bus.i_en       = en;
    bus.i_valid    = v;
    bus.i_data_bus = {dh, dl};
    bus.i_cmd      = {ch, cl};
    bus.i_ready    = rdy;
    #1;
    gr   = (v == 2'b11) ? (rr ? 2'b10 : 2'b01) : v;
    er   = (!r && en && q.size() < DEPTH) ? gr : 2'b00;
    head = (r || q.size() == 0) ? 34'd0 : q[0];
    check("ready", 64'(bus.o_ready), 64'(er));
    check("valid", 64'(bus.o_valid), 64'(!r && q.size() != 0));
    check("data", 64'(bus.o_data_bus), 64'(head[33:2]));
    check("cmd", 64'(bus.o_cmd), 64'(head[1:0]));
    if (r) begin
      q.delete();
      rr = 1'b1;
    end else begin
      pop = (q.size() != 0) && rdy;
      if (pop) void'(q.pop_front());
      if (|(v & er)) begin
        q.push_back(er[1] ? {dh, 1'b1, ch} : {dl, 1'b0, cl});
        rr = ~er[1];
      end
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    bus.i_en       = 1'b0;
    bus.i_valid    = 2'b00;
    bus.i_data_bus = '0;
    bus.i_cmd      = '0;
    bus.i_ready    = 1'b0;

    // Reset with both inputs requesting
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 2'b11, 32'h1111_1111, 32'h2222_2222,
           1'b0, 1'b1, 1'b1);
      check("rst_ready", 64'(bus.o_ready), 64'd0);
      check("rst_valid", 64'(bus.o_valid), 64'd0);
      check("rst_data", 64'(bus.o_data_bus), 64'd0);
      check("rst_cmd", 64'(bus.o_cmd), 64'd0);
    end
    step(1'b0, 1'b1, 2'b11, 32'h1111_1111, 32'h2222_2222,
         1'b0, 1'b1, 1'b1);
    check("post_rst_ready", 64'(bus.o_ready), 64'h2);
    idle(1'b1);
    check("first_data", 64'(bus.o_data_bus), 64'h1111_1111);
    check("first_cmd", 64'(bus.o_cmd), 64'h2);

    // Single low beat
    step(1'b0, 1'b1, 2'b01, 32'h0, 32'hAAAA_AAAA, 1'b0, 1'b1, 1'b1);
    check("low_ready", 64'(bus.o_ready), 64'h1);
    idle(1'b1);
    check("low_valid", 64'(bus.o_valid), 64'h1);
    check("low_data", 64'(bus.o_data_bus), 64'hAAAA_AAAA);
    check("low_cmd", 64'(bus.o_cmd), 64'h1);

    // Contention: alternating B/C, one beat per cycle
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b1, 2'b11, 32'hBBBB_BBBB, 32'hCCCC_CCCC,
           1'b0, 1'b1, 1'b1);
      check("cont_ready", 64'(bus.o_ready),
            (k % 2 == 0) ? 64'h2 : 64'h1);
      if (k > 0) begin
        check("cont_data", 64'(bus.o_data_bus),
              (k % 2 == 1) ? 64'hBBBB_BBBB : 64'hCCCC_CCCC);
        check("cont_cmd", 64'(bus.o_cmd),
              (k % 2 == 1) ? 64'h2 : 64'h1);
      end
    end
    idle(1'b1);
    idle(1'b1);
    check("drained", 64'(bus.o_valid), 64'd0);

    // Backpressure / full
    step(1'b0, 1'b1, 2'b01, 32'h0, 32'd1, 1'b0, 1'b0, 1'b0);
    check("bp_ready1", 64'(bus.o_ready), 64'h1);
    step(1'b0, 1'b1, 2'b01, 32'h0, 32'd2, 1'b0, 1'b0, 1'b0);
    check("bp_ready2", 64'(bus.o_ready), 64'h1);
    step(1'b0, 1'b1, 2'b01, 32'h0, 32'd3, 1'b0, 1'b0, 1'b0);
    check("bp_full_ready", 64'(bus.o_ready), 64'd0);
    check("bp_held", 64'(bus.o_data_bus), 64'd1);
    step(1'b0, 1'b1, 2'b01, 32'h0, 32'd3, 1'b0, 1'b0, 1'b1);
    check("bp_pop_ready", 64'(bus.o_ready), 64'd0);
    check("bp_pop_data", 64'(bus.o_data_bus), 64'd1);
    step(1'b0, 1'b1, 2'b01, 32'h0, 32'd3, 1'b0, 1'b0, 1'b1);
    check("bp_late_ready", 64'(bus.o_ready), 64'h1);
    check("bp_data2", 64'(bus.o_data_bus), 64'd2);
    idle(1'b1);
    check("bp_data3", 64'(bus.o_data_bus), 64'd3);
    idle(1'b1);

    // Enable gating keeps rr_ptr; drain continues
    step(1'b0, 1'b1, 2'b10, 32'h44, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'b11, 32'h55, 32'h66, 1'b0, 1'b0, 1'b1);
    check("en_ready", 64'(bus.o_ready), 64'd0);
    check("en_drain", 64'(bus.o_data_bus), 64'h44);
    step(1'b0, 1'b0, 2'b11, 32'h55, 32'h66, 1'b0, 1'b0, 1'b1);
    check("en_empty", 64'(bus.o_valid), 64'd0);
    step(1'b0, 1'b1, 2'b11, 32'h55, 32'h66, 1'b0, 1'b0, 1'b0);
    check("reen_ready", 64'(bus.o_ready), 64'h1);
    idle(1'b1);
    idle(1'b1);

    // Reset while full
    step(1'b0, 1'b1, 2'b01, 32'h0, 32'd5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'b01, 32'h0, 32'd6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("mid_rst_valid", 64'(bus.o_valid), 64'd0);
    step(1'b0, 1'b1, 2'b01, 32'h0, 32'd7, 1'b0, 1'b1, 1'b0);
    check("mid_rst_ready", 64'(bus.o_ready), 64'h1);
    idle(1'b1);
    check("mid_rst_data", 64'(bus.o_data_bus), 64'd7);
    check("mid_rst_cmd", 64'(bus.o_cmd), 64'h1);

    // Random traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) != 0),
           2'($urandom_range(0, 3)),
           $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
